// File: rtl/soc_msp430_reset_sequencer_if.sv
// Reset request and reset release signals between the MSP430 reset sequencer
// and its surroundings (global-signal block, request sources, reset consumers).
interface soc_msp430_reset_sequencer_if;
  logic       gsr;
  logic       gts;
  logic       ext_rst_req;
  logic       wdt_rst_req;
  logic       dbg_cpu_rst;
  logic       por_o;
  logic       dbg_rst_o;
  logic       puc_rst_o;
  logic       io_tristate_o;
  logic [3:0] rst_cause_o;
  logic [2:0] seq_state_o;

  modport master (
    output gsr, gts, ext_rst_req, wdt_rst_req, dbg_cpu_rst,
    input  por_o, dbg_rst_o, puc_rst_o, io_tristate_o, rst_cause_o, seq_state_o
  );

  modport slave (
    input  gsr, gts, ext_rst_req, wdt_rst_req, dbg_cpu_rst,
    output por_o, dbg_rst_o, puc_rst_o, io_tristate_o, rst_cause_o, seq_state_o
  );
endinterface

// File: rtl/soc_msp430_reset_sequencer.sv
// Ordered release of POR, debug and PUC resets for the MSP430 SoC, driven by
// the global set/reset pulse plus watchdog, external and debug reset requests.
module soc_msp430_reset_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int POR_HOLD    = 16,
  parameter int STAGGER     = 4,
  parameter int PUC_HOLD    = 8,
  parameter int CNT_W       = 8
) (
  input logic                           mclk,
  input logic                           rst,
  soc_msp430_reset_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_RESET_ALL = 3'd0,
    ST_HOLD_POR  = 3'd1,
    ST_REL_DBG   = 3'd2,
    ST_RUN       = 3'd3,
    ST_PUC_HOLD  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_HOLD - 1);
  localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0] PUC_LAST = CNT_W'(PUC_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] gsr_sync;
  logic [SYNC_STAGES-1:0] gts_sync;
  logic [SYNC_STAGES-1:0] ext_sync;
  logic                   gsr_s;
  logic                   gts_s;
  logic                   ext_s;
  logic                   any_req;
  logic                   por_next;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   por_q;
  logic                   dbg_q;
  logic                   puc_q;
  logic                   tri_q;
  logic [3:0]             cause_q;

  assign gsr_s   = gsr_sync[SYNC_STAGES-1];
  assign gts_s   = gts_sync[SYNC_STAGES-1];
  assign ext_s   = ext_sync[SYNC_STAGES-1];
  assign any_req = ext_s | bus.wdt_rst_req | bus.dbg_cpu_rst;

  // Value por_o takes at the coming edge, so the tristate flop tracks POR without lag.
  always_comb begin
    por_next = 1'b1;
    if (!gsr_s) begin
      case (state)
        ST_HOLD_POR: por_next = (cnt != POR_LAST);
        ST_REL_DBG,
        ST_RUN,
        ST_PUC_HOLD: por_next = 1'b0;
        default:     por_next = 1'b1;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      gsr_sync <= '1;
      gts_sync <= '1;
      ext_sync <= '0;
      state    <= ST_RESET_ALL;
      cnt      <= '0;
      por_q    <= 1'b1;
      dbg_q    <= 1'b1;
      puc_q    <= 1'b1;
      tri_q    <= 1'b1;
      cause_q  <= 4'b0001;
    end else begin
      gsr_sync <= {gsr_sync[SYNC_STAGES-2:0], bus.gsr};
      gts_sync <= {gts_sync[SYNC_STAGES-2:0], bus.gts};
      ext_sync <= {ext_sync[SYNC_STAGES-2:0], bus.ext_rst_req};
      tri_q    <= gts_s | por_next;

      // A synchronized GSR aborts whatever is in flight; nothing is partially released.
      if (gsr_s) begin
        state   <= ST_RESET_ALL;
        cnt     <= '0;
        por_q   <= 1'b1;
        dbg_q   <= 1'b1;
        puc_q   <= 1'b1;
        cause_q <= 4'b0001;
      end else begin
        case (state)
          ST_RESET_ALL: begin
            state <= ST_HOLD_POR;
            cnt   <= '0;
            por_q <= 1'b1;
            dbg_q <= 1'b1;
            puc_q <= 1'b1;
          end
          ST_HOLD_POR: begin
            if (cnt == POR_LAST) begin
              state <= ST_REL_DBG;
              cnt   <= '0;
              por_q <= 1'b0;
              dbg_q <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_REL_DBG: begin
            if (cnt == STG_LAST) begin
              state <= ST_RUN;
              cnt   <= '0;
              puc_q <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_RUN: begin
            if (any_req) begin
              state <= ST_PUC_HOLD;
              cnt   <= '0;
              puc_q <= 1'b1;
              if (ext_s)                cause_q <= 4'b0100;
              else if (bus.wdt_rst_req) cause_q <= 4'b0010;
              else                      cause_q <= 4'b1000;
            end
          end
          // Any request restarts the hold, so a level request stretches the PUC pulse.
          ST_PUC_HOLD: begin
            if (any_req) begin
              cnt <= '0;
            end else if (cnt == PUC_LAST) begin
              state <= ST_RUN;
              cnt   <= '0;
              puc_q <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= ST_RESET_ALL;
            cnt   <= '0;
            por_q <= 1'b1;
            dbg_q <= 1'b1;
            puc_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.por_o         = por_q;
  assign bus.dbg_rst_o     = dbg_q;
  assign bus.puc_rst_o     = puc_q;
  assign bus.io_tristate_o = tri_q;
  assign bus.rst_cause_o   = cause_q;
  assign bus.seq_state_o   = state;

endmodule

// File: tb/tb_soc_msp430_reset_sequencer.sv
// Bench for soc_msp430_reset_sequencer: directed vector table, hand-written
// corner sequences, then random traffic against a timeline-based reference model.
module tb_soc_msp430_reset_sequencer;

  localparam int SYNC_STAGES = 2;
  localparam int POR_HOLD    = 16;
  localparam int STAGGER     = 4;
  localparam int PUC_HOLD    = 8;
  localparam int CNT_W       = 8;
  localparam int RUN_AGE     = POR_HOLD + STAGGER + 1;

  typedef struct {
    int         cycles;
    logic       rst;
    logic       gsr;
    logic       gts;
    logic       ext;
    logic       wdt;
    logic       dbg;
    logic [10:0] exp;
  } vec_t;

  logic mclk = 1'b0;
  logic rst;

  soc_msp430_reset_sequencer_if bus();

  soc_msp430_reset_sequencer #(
    .SYNC_STAGES (SYNC_STAGES),
    .POR_HOLD    (POR_HOLD),
    .STAGGER     (STAGGER),
    .PUC_HOLD    (PUC_HOLD),
    .CNT_W       (CNT_W)
  ) dut (
    .mclk (mclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 mclk = ~mclk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: synchronizers as delay queues, the release sequence as the
  // number of edges since GSR was last seen, PUC as remaining pulse length.
  logic        gsr_hist[$];
  logic        gts_hist[$];
  logic        ext_hist[$];
  int          age;
  int          puc_left;
  logic [3:0]  m_cause;
  logic [10:0] m_exp;

  function automatic logic [10:0] pk(logic por, logic dbg, logic puc, logic tristate,
                                     logic [3:0] cause, logic [2:0] st);
    return {por, dbg, puc, tristate, cause, st};
  endfunction

  function automatic vec_t mkv(int cycles, logic r, logic g, logic t, logic e,
                               logic w, logic d, logic [10:0] exp);
    vec_t v;
    v.cycles = cycles; v.rst = r; v.gsr = g; v.gts = t;
    v.ext = e; v.wdt = w; v.dbg = d; v.exp = exp;
    return v;
  endfunction

  task automatic modelStep();
    logic gs, ts, es, req, por;
    logic [2:0] st;
    if (rst) begin
      gsr_hist = {}; gts_hist = {}; ext_hist = {};
      for (int i = 0; i < SYNC_STAGES; i++) begin
        gsr_hist.push_back(1'b1);
        gts_hist.push_back(1'b1);
        ext_hist.push_back(1'b0);
      end
      age = 0; puc_left = 0; m_cause = 4'b0001;
      m_exp = pk(1, 1, 1, 1, 4'b0001, 3'd0);
      return;
    end
    gs = gsr_hist[0]; ts = gts_hist[0]; es = ext_hist[0];
    if (gs) begin
      age = 0; puc_left = 0; m_cause = 4'b0001;
    end else begin
      if (age >= RUN_AGE) begin
        req = es | bus.wdt_rst_req | bus.dbg_cpu_rst;
        if (req) begin
          if (puc_left == 0)
            m_cause = es ? 4'b0100 : (bus.wdt_rst_req ? 4'b0010 : 4'b1000);
          puc_left = PUC_HOLD;
        end else if (puc_left > 0) begin
          puc_left--;
        end
      end
      if (age < RUN_AGE) age++;
    end
    por = (age <= POR_HOLD);
    if (age == 0)             st = 3'd0;
    else if (age <= POR_HOLD) st = 3'd1;
    else if (age < RUN_AGE)   st = 3'd2;
    else                      st = (puc_left > 0) ? 3'd4 : 3'd3;
    m_exp = pk(por, por, (age < RUN_AGE) || (puc_left > 0), ts | por, m_cause, st);
    void'(gsr_hist.pop_front()); gsr_hist.push_back(bus.gsr);
    void'(gts_hist.pop_front()); gts_hist.push_back(bus.gts);
    void'(ext_hist.pop_front()); ext_hist.push_back(bus.ext_rst_req);
  endtask

  task automatic tick();
    @(posedge mclk);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(logic r, logic g, logic t, logic e, logic w, logic d);
    rst = r;
    bus.gsr = g;
    bus.gts = t;
    bus.ext_rst_req = e;
    bus.wdt_rst_req = w;
    bus.dbg_cpu_rst = d;
  endtask

  task automatic checkOutput(string name, logic [10:0] exp);
    logic [10:0] got;
    got = pk(bus.por_o, bus.dbg_rst_o, bus.puc_rst_o, bus.io_tristate_o,
             bus.rst_cause_o, bus.seq_state_o);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: {por,dbg,puc,tri,cause,state} got %b required %b", name, got, exp);
    end
  endtask

  task automatic checkValue(string name, int got, int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  vec_t vecs[$];

  initial begin
    int high, guard, por_fall, puc_fall, n;
    logic r_gsr, r_gts, r_ext, r_dbg;

    applyStimulus(1, 1, 0, 0, 0, 0);

    // Power-up, watchdog PUC, then GTS round trip; edge counts follow gsr release.
    vecs.push_back(mkv( 2, 1, 1, 0, 0, 0, 0, pk(1, 1, 1, 1, 4'b0001, 3'd0)));
    vecs.push_back(mkv(50, 0, 1, 0, 0, 0, 0, pk(1, 1, 1, 1, 4'b0001, 3'd0)));
    vecs.push_back(mkv( 2, 0, 0, 0, 0, 0, 0, pk(1, 1, 1, 1, 4'b0001, 3'd0)));
    vecs.push_back(mkv( 1, 0, 0, 0, 0, 0, 0, pk(1, 1, 1, 1, 4'b0001, 3'd1)));
    vecs.push_back(mkv(15, 0, 0, 0, 0, 0, 0, pk(1, 1, 1, 1, 4'b0001, 3'd1)));
    vecs.push_back(mkv( 1, 0, 0, 0, 0, 0, 0, pk(0, 0, 1, 0, 4'b0001, 3'd2)));
    vecs.push_back(mkv( 3, 0, 0, 0, 0, 0, 0, pk(0, 0, 1, 0, 4'b0001, 3'd2)));
    vecs.push_back(mkv( 1, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 4'b0001, 3'd3)));
    vecs.push_back(mkv( 1, 0, 0, 0, 0, 1, 0, pk(0, 0, 1, 0, 4'b0010, 3'd4)));
    vecs.push_back(mkv( 7, 0, 0, 0, 0, 0, 0, pk(0, 0, 1, 0, 4'b0010, 3'd4)));
    vecs.push_back(mkv( 1, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 4'b0010, 3'd3)));
    vecs.push_back(mkv( 2, 0, 0, 1, 0, 0, 0, pk(0, 0, 0, 0, 4'b0010, 3'd3)));
    vecs.push_back(mkv( 1, 0, 0, 1, 0, 0, 0, pk(0, 0, 0, 1, 4'b0010, 3'd3)));
    vecs.push_back(mkv( 2, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 1, 4'b0010, 3'd3)));
    vecs.push_back(mkv( 1, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 4'b0010, 3'd3)));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].gsr, vecs[i].gts, vecs[i].ext, vecs[i].wdt, vecs[i].dbg);
      repeat (vecs[i].cycles) tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // ext reaches the FSM two edges late; wdt is timed to arrive with it, ext wins.
    applyStimulus(0, 0, 0, 1, 0, 0);
    tick(); tick();
    checkOutput("simul_wait", pk(0, 0, 0, 0, 4'b0010, 3'd3));
    applyStimulus(0, 0, 0, 1, 1, 0);
    tick();
    checkOutput("simul_start", pk(0, 0, 1, 0, 4'b0100, 3'd4));
    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (9) tick();
    checkOutput("simul_hold", pk(0, 0, 1, 0, 4'b0100, 3'd4));
    tick();
    checkOutput("simul_end", pk(0, 0, 0, 0, 4'b0100, 3'd3));

    // dbg sampled on 20 edges; PUC ends PUC_HOLD edges after the last one.
    high = 0;
    applyStimulus(0, 0, 0, 0, 0, 1);
    repeat (20) begin
      tick();
      if (bus.puc_rst_o === 1'b1) high++;
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    guard = 0;
    while (bus.puc_rst_o === 1'b1 && guard < 40) begin
      tick();
      guard++;
      if (bus.puc_rst_o === 1'b1) high++;
    end
    checkValue("dbg_stretch_width", high, 20 + PUC_HOLD - 1);
    checkOutput("dbg_stretch_end", pk(0, 0, 0, 0, 4'b1000, 3'd3));

    // GSR pulse while the debug reset has just been released.
    applyStimulus(0, 1, 0, 0, 0, 0);
    repeat (3) tick();
    checkOutput("abort_prep", pk(1, 1, 1, 1, 4'b0001, 3'd0));
    applyStimulus(0, 0, 0, 0, 0, 0);
    n = 0;
    while (bus.seq_state_o !== 3'd2 && n < 60) begin
      tick();
      n++;
    end
    checkValue("abort_rel_dbg_edge", n, SYNC_STAGES + POR_HOLD + 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    tick(); tick();
    checkOutput("abort_pre", pk(0, 0, 1, 0, 4'b0001, 3'd2));
    tick();
    checkOutput("abort_hit", pk(1, 1, 1, 1, 4'b0001, 3'd0));
    tick(); tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    por_fall = 0;
    puc_fall = 0;
    for (int e = 1; e <= 60; e++) begin
      tick();
      if (por_fall == 0 && bus.por_o === 1'b0) por_fall = e;
      if (bus.puc_rst_o === 1'b0) begin
        puc_fall = e;
        break;
      end
    end
    checkValue("abort_por_fall", por_fall, SYNC_STAGES + POR_HOLD + 1);
    checkValue("abort_puc_fall", puc_fall, SYNC_STAGES + POR_HOLD + STAGGER + 1);
    checkOutput("abort_run", pk(0, 0, 0, 0, 4'b0001, 3'd3));

    // Synchronous reset during PUC_HOLD takes effect only at the edge.
    applyStimulus(0, 0, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick(); tick();
    applyStimulus(1, 0, 0, 0, 0, 0);
    @(negedge mclk);
    checkOutput("rst_before_edge", pk(0, 0, 1, 0, 4'b0010, 3'd4));
    tick();
    checkOutput("rst_after_edge", pk(1, 1, 1, 1, 4'b0001, 3'd0));
    applyStimulus(0, 0, 0, 0, 0, 0);

    r_gsr = 1'b0; r_gts = 1'b0; r_ext = 1'b0; r_dbg = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (r_gsr) r_gsr = ($urandom_range(0, 3) != 0);
      else       r_gsr = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 39) == 0) r_gts = ~r_gts;
      if (r_ext) r_ext = ($urandom_range(0, 5) != 0);
      else       r_ext = ($urandom_range(0, 49) == 0);
      if (r_dbg) r_dbg = ($urandom_range(0, 9) != 0);
      else       r_dbg = ($urandom_range(0, 69) == 0);
      applyStimulus(($urandom_range(0, 399) == 0), r_gsr, r_gts, r_ext,
                    ($urandom_range(0, 24) == 0), r_dbg);
      tick();
      checkOutput($sformatf("rand%0d", c), m_exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
